// File: rtl/porti_pkg.sv
// Shared constants for the porti_capture input-port peripheral: register
// addresses on the peripheral bus and the debounce counter width.
package porti_pkg;

  localparam logic [1:0] PCAP_LEVEL = 2'd0;
  localparam logic [1:0] PCAP_RISE  = 2'd1;
  localparam logic [1:0] PCAP_FALL  = 2'd2;
  localparam logic [1:0] PCAP_MASK  = 2'd3;

  localparam int PCAP_CNTW = 8;

endpackage

// File: rtl/porti_debounce.sv
// One input line: two-flop synchronizer, debounce counter, stable value and
// single-cycle edge pulses that coincide with the stable value changing.
module porti_debounce
  import porti_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [PCAP_CNTW-1:0] CNT_LAST = PCAP_CNTW'(DEBOUNCE - 1);

  logic                 s1_q, s2_q;
  logic                 stable_q, stable_d;
  logic [PCAP_CNTW-1:0] cnt_q, cnt_d;

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    fall     = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
      rise     = s2_q;
      fall     = ~s2_q;
    end else begin
      cnt_d = cnt_q + PCAP_CNTW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= din;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/porti_capture.sv
// Memory-mapped input port: per-bit debounce, sticky write-1-to-clear edge
// flags, interrupt mask and a registered level interrupt request.
module porti_capture
  import porti_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEBOUNCE = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] PORTI,
  input  logic             cs,
  input  logic             wen,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             irq
);

  logic [WIDTH-1:0] level, rise_set, fall_set;
  logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d, mask_q, mask_d;
  logic [WIDTH-1:0] rise_clr, fall_clr;
  logic             irq_q, irq_d;
  logic             wr;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    porti_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_deb (
      .clk   (CLK),
      .rst   (RESET),
      .din   (PORTI[i]),
      .stable(level[i]),
      .rise  (rise_set[i]),
      .fall  (fall_set[i])
    );
  end

  assign wr = cs & wen;

  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    mask_d   = mask_q;
    if (wr) begin
      case (addr)
        PCAP_RISE: rise_clr = din;
        PCAP_FALL: fall_clr = din;
        PCAP_MASK: mask_d   = din;
        default:   ;
      endcase
    end
    // A new edge in the same cycle as its clear keeps the flag set.
    rise_d = (rise_q & ~rise_clr) | rise_set;
    fall_d = (fall_q & ~fall_clr) | fall_set;
    irq_d  = |((rise_q | fall_q) & mask_q);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rise_q <= '0;
      fall_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      PCAP_LEVEL: dout = level;
      PCAP_RISE:  dout = rise_q;
      PCAP_FALL:  dout = fall_q;
      PCAP_MASK:  dout = mask_q;
      default:    dout = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_porti_capture.sv
// Directed bench for porti_capture (WIDTH=32, DEBOUNCE=4): reset, level and
// edge latency, glitch rejection, interrupt masking/clear, set-vs-clear, reset.
module tb_porti_capture;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] PORTI = '0;
  logic        cs = 1'b0;
  logic        wen = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  porti_capture #(
    .WIDTH   (32),
    .DEBOUNCE(4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .PORTI(PORTI),
    .cs   (cs),
    .wen  (wen),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs   = 1'b1;
    wen  = 1'b1;
    addr = a;
    din  = d;
    tick(1);
    cs   = 1'b0;
    wen  = 1'b0;
    din  = '0;
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    check(tag, {31'h0, irq}, {31'h0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset state, then a line held high through release
    tick(2);
    rd(2'd0, 32'h0, "rst_level");
    rd(2'd1, 32'h0, "rst_rise");
    rd(2'd2, 32'h0, "rst_fall");
    rd(2'd3, 32'h0, "rst_mask");
    chk_irq(1'b0, "rst_irq");
    PORTI = 32'h4;
    #1;
    RESET = 1'b0;
    tick(5);
    rd(2'd0, 32'h0, "s1_level_edge5");
    tick(1);
    rd(2'd0, 32'h4, "s1_level_edge6");
    rd(2'd1, 32'h4, "s1_rise_edge6");
    tick(1);
    chk_irq(1'b0, "s1_irq_masked");

    // 2: long high, then fall
    tick(94);
    rd(2'd0, 32'h4, "s2_level_hold");
    rd(2'd2, 32'h0, "s2_fall_none");
    PORTI = 32'h0;
    tick(5);
    rd(2'd0, 32'h4, "s2_level_edge5");
    tick(1);
    rd(2'd0, 32'h0, "s2_level_edge6");
    rd(2'd2, 32'h4, "s2_fall_set");
    rd(2'd1, 32'h4, "s2_rise_sticky");
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd1, 32'h0, "s2_rise_clr");
    rd(2'd2, 32'h0, "s2_fall_clr");

    // 3: glitch rejection (3 cycles) and acceptance (4 cycles) on bit 0
    PORTI = 32'h1;
    tick(3);
    PORTI = 32'h0;
    tick(1);
    check("s3_cnt_peak", {24'h0, dut.g_bit[0].u_deb.cnt_q}, 32'd2);
    tick(7);
    rd(2'd0, 32'h0, "s3_glitch_level");
    rd(2'd1, 32'h0, "s3_glitch_rise");
    check("s3_glitch_cnt", {24'h0, dut.g_bit[0].u_deb.cnt_q}, 32'd0);
    PORTI = 32'h1;
    tick(4);
    PORTI = 32'h0;
    tick(2);
    rd(2'd0, 32'h1, "s3_pulse_level");
    rd(2'd1, 32'h1, "s3_pulse_rise");
    tick(10);
    rd(2'd0, 32'h0, "s3_pulse_level_back");
    rd(2'd2, 32'h1, "s3_pulse_fall");
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);

    // 4: mask, interrupt and write-1-to-clear
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h4, "s4_mask");
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h0, "s4_level_ro");
    chk_irq(1'b0, "s4_irq_idle");
    PORTI = 32'h4;
    tick(6);
    rd(2'd1, 32'h4, "s4_rise");
    chk_irq(1'b0, "s4_irq_lag");
    tick(1);
    chk_irq(1'b1, "s4_irq_set");
    wr(2'd1, 32'h0);
    rd(2'd1, 32'h4, "s4_clr_zero");
    wr(2'd1, 32'h4);
    rd(2'd1, 32'h0, "s4_clr");
    chk_irq(1'b1, "s4_irq_hold");
    tick(1);
    chk_irq(1'b0, "s4_irq_clr");

    // 5: clear lands on the same edge as a new rise
    PORTI = 32'h0;
    tick(6);
    rd(2'd2, 32'h4, "s5_fall");
    wr(2'd2, 32'h4);
    tick(1);
    PORTI = 32'h4;
    tick(5);
    wr(2'd1, 32'h4);
    rd(2'd1, 32'h4, "s5_set_wins");
    tick(1);
    chk_irq(1'b1, "s5_irq");

    // 6: asynchronous reset mid-debounce
    PORTI = 32'h0;
    tick(4);
    check("s6_cnt_mid", {24'h0, dut.g_bit[2].u_deb.cnt_q}, 32'd2);
    #1;
    RESET = 1'b1;
    #1;
    chk_irq(1'b0, "s6_irq_async");
    check("s6_cnt_async", {24'h0, dut.g_bit[2].u_deb.cnt_q}, 32'd0);
    rd(2'd1, 32'h0, "s6_rise_async");
    rd(2'd2, 32'h0, "s6_fall_async");
    rd(2'd3, 32'h0, "s6_mask_async");
    rd(2'd0, 32'h0, "s6_level_async");
    PORTI = 32'h4;
    tick(1);
    RESET = 1'b0;
    tick(5);
    rd(2'd0, 32'h0, "s6_level_edge5");
    tick(1);
    rd(2'd0, 32'h4, "s6_level_edge6");
    rd(2'd1, 32'h4, "s6_rise_edge6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
